plot_scheduler: RTL

Frame-level sequencer and arbiter for the single VGA adapter pixel-write port. Each frame it sweeps the 160x120 screen to background, then shares the port among three pixel requesters: ship, asteroid plotter and bullet plotter. It sits between the object plotters and the VGA adapter inside the graphics path, and is driven by the game frame tick.

---
 rtl/plot_scheduler_if.sv | 27 ++
 rtl/plot_scheduler.sv | 184 ++++++++++++++++++
 2 files changed

// File: rtl/plot_scheduler_if.sv
// Pixel-request and VGA-write bundle between the object plotters, the
// plot_scheduler arbiter and the VGA adapter.
interface plot_scheduler_if;
  logic [2:0]  req;
  logic [23:0] req_x;
  logic [20:0] req_y;
  logic [8:0]  req_colour;
  logic [2:0]  req_done;
  logic [2:0]  gnt;
  logic        draw_start;
  logic [7:0]  vga_x;
  logic [6:0]  vga_y;
  logic [2:0]  vga_colour;
  logic        vga_plot;
  logic        busy;
  logic        overrun;

  modport master (
    output req, req_x, req_y, req_colour, req_done,
    input  gnt, draw_start, vga_x, vga_y, vga_colour, vga_plot, busy, overrun
  );

  modport slave (
    input  req, req_x, req_y, req_colour, req_done,
    output gnt, draw_start, vga_x, vga_y, vga_colour, vga_plot, busy, overrun
  );
endinterface

// File: rtl/plot_scheduler.sv
// Per-frame background clear followed by arbitration of the single VGA pixel port.
// Define SHIP_PRIORITY_EN to give the ship (requester 0) absolute priority.
module plot_scheduler #(
  parameter int          X_MAX         = 160,
  parameter int          Y_MAX         = 120,
  parameter logic [2:0]  BG_COLOUR     = 3'b000,
  parameter logic [15:0] SERVE_TIMEOUT = 16'd4096
) (
  input  logic            clk,
  input  logic            resetn,
  input  logic            frame_tick,
  plot_scheduler_if.slave bus
);

  localparam logic [7:0]  X_LAST = 8'(X_MAX - 1);
  localparam logic [6:0]  Y_LAST = 7'(Y_MAX - 1);
  localparam logic [15:0] T_LAST = SERVE_TIMEOUT - 16'd1;

  typedef enum logic [1:0] {IDLE, CLEAR, SERVE} state_t;

  state_t      state_reg;
  logic [7:0]  x_cnt_reg;
  logic [6:0]  y_cnt_reg;
  logic [15:0] timeout_reg;
  logic [1:0]  rr_ptr_reg;
  logic        draw_start_reg;
  logic [7:0]  vga_x_reg;
  logic [6:0]  vga_y_reg;
  logic [2:0]  vga_colour_reg;
  logic        vga_plot_reg;
  logic        busy_reg;
  logic        overrun_reg;

  logic [7:0]  req_xs [3];
  logic [6:0]  req_ys [3];
  logic [2:0]  req_cs [3];
  logic [2:0]  eligible;
  logic        win_valid;
  logic [1:0]  win_idx;
  logic        grant_any;
  logic [2:0]  gnt_next;

  generate
    for (genvar gi = 0; gi < 3; gi++) begin : g_unpack
      assign req_xs[gi]   = bus.req_x[8*gi +: 8];
      assign req_ys[gi]   = bus.req_y[7*gi +: 7];
      assign req_cs[gi]   = bus.req_colour[3*gi +: 3];
      assign eligible[gi] = bus.req[gi] & ~bus.req_done[gi];
    end
  endgenerate

`ifdef SHIP_PRIORITY_EN
  always_comb begin
    win_valid = 1'b0;
    win_idx   = 2'd0;
    if (eligible[0]) begin
      win_valid = 1'b1;
      win_idx   = 2'd0;
    end else if (rr_ptr_reg == 2'd1) begin
      if (eligible[2]) begin
        win_valid = 1'b1;
        win_idx   = 2'd2;
      end else if (eligible[1]) begin
        win_valid = 1'b1;
        win_idx   = 2'd1;
      end
    end else begin
      if (eligible[1]) begin
        win_valid = 1'b1;
        win_idx   = 2'd1;
      end else if (eligible[2]) begin
        win_valid = 1'b1;
        win_idx   = 2'd2;
      end
    end
  end
`else
  // Walk the offsets from farthest to nearest so the nearest eligible one wins.
  always_comb begin
    logic [1:0] cand;
    win_valid = 1'b0;
    win_idx   = 2'd0;
    cand      = 2'd0;
    for (int k = 3; k >= 1; k--) begin
      cand = 2'((int'(rr_ptr_reg) + k) % 3);
      if (eligible[cand]) begin
        win_valid = 1'b1;
        win_idx   = cand;
      end
    end
  end
`endif

  // The draw_start cycle lets requesters rewind their walks before any grant.
  assign grant_any = (state_reg == SERVE) && !draw_start_reg && win_valid;
  assign gnt_next  = grant_any ? (3'b001 << win_idx) : 3'b000;

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state_reg      <= IDLE;
      x_cnt_reg      <= 8'd0;
      y_cnt_reg      <= 7'd0;
      timeout_reg    <= 16'd0;
      rr_ptr_reg     <= 2'd2;
      draw_start_reg <= 1'b0;
      vga_x_reg      <= 8'd0;
      vga_y_reg      <= 7'd0;
      vga_colour_reg <= 3'd0;
      vga_plot_reg   <= 1'b0;
      busy_reg       <= 1'b0;
      overrun_reg    <= 1'b0;
    end else begin
      draw_start_reg <= 1'b0;
      vga_plot_reg   <= 1'b0;
      if (frame_tick && (state_reg != IDLE)) begin
        overrun_reg <= 1'b1;
      end
      case (state_reg)
        IDLE: begin
          if (frame_tick) begin
            state_reg <= CLEAR;
            x_cnt_reg <= 8'd0;
            y_cnt_reg <= 7'd0;
            busy_reg  <= 1'b1;
          end
        end
        CLEAR: begin
          vga_x_reg      <= x_cnt_reg;
          vga_y_reg      <= y_cnt_reg;
          vga_colour_reg <= BG_COLOUR;
          vga_plot_reg   <= 1'b1;
          if (x_cnt_reg == X_LAST) begin
            x_cnt_reg <= 8'd0;
            if (y_cnt_reg == Y_LAST) begin
              y_cnt_reg      <= 7'd0;
              state_reg      <= SERVE;
              draw_start_reg <= 1'b1;
              timeout_reg    <= 16'd0;
            end else begin
              y_cnt_reg <= y_cnt_reg + 7'd1;
            end
          end else begin
            x_cnt_reg <= x_cnt_reg + 8'd1;
          end
        end
        SERVE: begin
          timeout_reg <= timeout_reg + 16'd1;
          if (grant_any) begin
            vga_x_reg      <= req_xs[win_idx];
            vga_y_reg      <= req_ys[win_idx];
            vga_colour_reg <= req_cs[win_idx];
            vga_plot_reg   <= 1'b1;
`ifdef SHIP_PRIORITY_EN
            if (win_idx != 2'd0) begin
              rr_ptr_reg <= win_idx;
            end
`else
            rr_ptr_reg <= win_idx;
`endif
          end
          // A grant on the exit cycle is still plotted on the first IDLE cycle.
          if (((bus.req_done == 3'b111) && !grant_any) || (timeout_reg == T_LAST)) begin
            state_reg <= IDLE;
            busy_reg  <= 1'b0;
          end
        end
        default: begin
          state_reg <= IDLE;
          busy_reg  <= 1'b0;
        end
      endcase
    end
  end

  assign bus.gnt        = gnt_next;
  assign bus.draw_start = draw_start_reg;
  assign bus.vga_x      = vga_x_reg;
  assign bus.vga_y      = vga_y_reg;
  assign bus.vga_colour = vga_colour_reg;
  assign bus.vga_plot   = vga_plot_reg;
  assign bus.busy       = busy_reg;
  assign bus.overrun    = overrun_reg;

endmodule
